alu_div_seq: RTL and testbench



---
 rtl/alu10181_pkg.sv | 19 +
 rtl/alu_div_seq_addsub.sv | 30 +++
 rtl/alu_div_seq.sv | 144 ++++++++++++++
 tb/tb_alu_div_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu10181_pkg.sv
// Shared definitions for the divider that drives the 10181 ALU slice:
// FSM state encoding, 10181 function-select codes and the arithmetic mode bit.
package alu10181_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_t;

   // 10181 function selects (mode M=0, arithmetic)
   localparam logic [3:0] F_A_MINUS_B = 4'b0110;  // A - B, needs CIN=1
   localparam logic [3:0] F_A_PLUS_B  = 4'b1001;  // A + B, CIN=0
   localparam logic [3:0] F_ZERO_SEL  = 4'b0000;  // pass A through unchanged

   localparam logic M_ARITH = 1'b0;

endpackage

// File: rtl/alu_div_seq_addsub.sv
// Combinational WIDTH+1 add/subtract behaving like a chain of 10181 slices
// in arithmetic mode. Kept separate so a gate-level slice model can replace it.
module div_addsub_step
   import alu10181_pkg::*;
#(
   parameter int WIDTH = 36
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic [3:0]     alu_s,
   input  logic           alu_cin,
   output logic [WIDTH:0] y
);

   logic [WIDTH:0] cin_ext;

   assign cin_ext = {{WIDTH{1'b0}}, alu_cin};

   // Decode the function select into add, subtract or pass-through of A.
   always_comb begin
      // NOTE: y gets a value before the case so no path leaves it unassigned (no latch).
      y = a;
      case (alu_s)
         F_A_MINUS_B: y = a + ~b + cin_ext;
         F_A_PLUS_B:  y = a + b + cin_ext;
         default:     y = a;
      endcase
   end

endmodule

// File: rtl/alu_div_seq.sv
// Iterative unsigned non-restoring divider. Each STEP cycle shifts {R,Q} left
// and either subtracts or adds the divisor depending on the sign of R; a final
// FIX cycle restores a negative remainder. The per-step 10181 select is exported.
module alu_div_seq
   import alu10181_pkg::*;
#(
   parameter int WIDTH = 36,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic [3:0]       alu_s,
   output logic             alu_m,
   output logic             alu_cin
);

   div_state_t       state, state_next;
   logic [WIDTH:0]   r;        // partial remainder, two's complement
   logic [WIDTH-1:0] q;        // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] d;        // captured divisor
   logic [CW-1:0]    cnt;      // remaining STEP iterations

   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   alu_a;
   logic [WIDTH:0]   alu_b;
   logic [WIDTH:0]   alu_y;

   assign alu_m = M_ARITH;

   // R shifted left with the next dividend bit entering at the bottom
   assign r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
   assign alu_a = (state == ST_STEP) ? r_sh : r;
   assign alu_b = {1'b0, d};

   div_addsub_step #(.WIDTH(WIDTH)) u_step (
      .a       (alu_a),
      .b       (alu_b),
      .alu_s   (alu_s),
      .alu_cin (alu_cin),
      .y       (alu_y)
   );

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         state <= state_next;
      end
   end

   // Next-state decode plus the status and 10181 select outputs.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      alu_s      = F_ZERO_SEL;
      alu_cin    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = (divisor == '0) ? ST_DONE : ST_STEP;
            end
         end
         ST_STEP: begin
            busy = 1'b1;
            if (!r[WIDTH]) begin
               alu_s   = F_A_MINUS_B;
               alu_cin = 1'b1;
            end else begin
               alu_s   = F_A_PLUS_B;
               alu_cin = 1'b0;
            end
            if (cnt == CW'(1)) begin
               state_next = ST_FIX;
            end
         end
         ST_FIX: begin
            busy = 1'b1;
            if (r[WIDTH]) begin
               alu_s = F_A_PLUS_B;
            end
            state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, shift/add-subtract iterations, result load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r         <= '0;
         q         <= '0;
         d         <= '0;
         cnt       <= '0;
         div_zero  <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (divisor != '0) begin
                     r        <= '0;
                     q        <= dividend;
                     d        <= divisor;
                     cnt      <= CW'(WIDTH);
                     div_zero <= 1'b0;
                  end else begin
                     div_zero  <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                  end
               end
            end
            ST_STEP: begin
               r   <= alu_y;
               q   <= {q[WIDTH-2:0], ~alu_y[WIDTH]};
               cnt <= cnt - CW'(1);
            end
            ST_FIX: begin
               r         <= alu_y;
               quotient  <= q;
               remainder <= alu_y[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq: an 8-bit instance for latency, boundary,
// ignore and reset scenarios, and a 36-bit instance for full-width results.
module tb_alu_div_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        start8 = 1'b0;
   logic [7:0]  dividend8 = '0, divisor8 = '0;
   logic        busy8, done8, div_zero8, alu_m8, alu_cin8;
   logic [7:0]  quotient8, remainder8;
   logic [3:0]  alu_s8;

   logic        start36 = 1'b0;
   logic [35:0] dividend36 = '0, divisor36 = '0;
   logic        busy36, done36, div_zero36, alu_m36, alu_cin36;
   logic [35:0] quotient36, remainder36;
   logic [3:0]  alu_s36;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   alu_div_seq #(.WIDTH(8)) u_div8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
      .busy(busy8), .done(done8), .div_zero(div_zero8), .quotient(quotient8),
      .remainder(remainder8), .alu_s(alu_s8), .alu_m(alu_m8), .alu_cin(alu_cin8)
   );

   alu_div_seq #(.WIDTH(36)) u_div36 (
      .clk(clk), .rst_n(rst_n), .start(start36), .dividend(dividend36), .divisor(divisor36),
      .busy(busy36), .done(done36), .div_zero(div_zero36), .quotient(quotient36),
      .remainder(remainder36), .alu_s(alu_s36), .alu_m(alu_m36), .alu_cin(alu_cin36)
   );

   // Runs one 8-bit op starting at #1 after an edge with the DUT idle.
   // lat counts edges from the start-sampling edge (inclusive) to done.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output int busy_n);
      start8 = 1'b1; dividend8 = a; divisor8 = b;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 1; busy_n = 0;
      while (!done8 && lat < 100) begin
         if (busy8) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic op36(input logic [35:0] a, input logic [35:0] b, output int lat);
      start36 = 1'b1; dividend36 = a; divisor36 = b;
      @(posedge clk); #1;
      start36 = 1'b0;
      lat = 1;
      while (!done36 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if ({busy8, done8, div_zero8, quotient8, remainder8, alu_s8, alu_m8, alu_cin8} !== '0)
         $display("FAIL reset8_outputs: got %h want 0",
                  {busy8, done8, div_zero8, quotient8, remainder8, alu_s8, alu_m8, alu_cin8});
      else pass_cnt++;
      total_cnt++;
      if ({busy36, done36, div_zero36, quotient36, remainder36, alu_s36, alu_m36, alu_cin36} !== '0)
         $display("FAIL reset36_outputs: got %h want 0",
                  {busy36, done36, div_zero36, quotient36, remainder36, alu_s36, alu_m36, alu_cin36});
      else pass_cnt++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if ({busy8, done8} !== 2'b00)
         $display("FAIL reset_release_idle: got busy/done %b want 00", {busy8, done8});
      else pass_cnt++;
   endtask

   task automatic test_basic();
      int lat, busy_n;
      op8(8'd100, 8'd7, lat, busy_n);
      total_cnt++;
      if (lat !== 10) $display("FAIL basic_latency: got %0d want 10", lat); else pass_cnt++;
      total_cnt++;
      if (busy_n !== 9) $display("FAIL basic_busy_cycles: got %0d want 9", busy_n); else pass_cnt++;
      total_cnt++;
      if (quotient8 !== 8'd14) $display("FAIL basic_quotient: got %0d want 14", quotient8); else pass_cnt++;
      total_cnt++;
      if (remainder8 !== 8'd2) $display("FAIL basic_remainder: got %0d want 2", remainder8); else pass_cnt++;
      total_cnt++;
      if (div_zero8 !== 1'b0) $display("FAIL basic_div_zero: got %b want 0", div_zero8); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (done8 !== 1'b0) $display("FAIL basic_done_single_cycle: got %b want 0", done8); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat, busy_n;
      op8(8'd255, 8'd1, lat, busy_n);
      total_cnt++;
      if ({quotient8, remainder8} !== {8'd255, 8'd0})
         $display("FAIL b2b_255_1: got q=%0d r=%0d want q=255 r=0", quotient8, remainder8);
      else pass_cnt++;
      // first cycle after DONE: start here must be accepted
      @(posedge clk); #1;
      op8(8'd5, 8'd9, lat, busy_n);
      total_cnt++;
      if (lat !== 10) $display("FAIL b2b_second_latency: got %0d want 10", lat); else pass_cnt++;
      total_cnt++;
      if ({quotient8, remainder8} !== {8'd0, 8'd5})
         $display("FAIL b2b_5_9: got q=%0d r=%0d want q=0 r=5", quotient8, remainder8);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_div_zero();
      int lat, busy_n;
      op8(8'd77, 8'd0, lat, busy_n);
      total_cnt++;
      if (lat !== 1) $display("FAIL dz_latency: got %0d want 1", lat); else pass_cnt++;
      total_cnt++;
      if (busy_n !== 0) $display("FAIL dz_busy_cycles: got %0d want 0", busy_n); else pass_cnt++;
      total_cnt++;
      if ({div_zero8, quotient8, remainder8} !== {1'b1, 8'hFF, 8'd77})
         $display("FAIL dz_results: got dz=%b q=%h r=%0d want dz=1 q=ff r=77",
                  div_zero8, quotient8, remainder8);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (div_zero8 !== 1'b1) $display("FAIL dz_held: got %b want 1", div_zero8); else pass_cnt++;
   endtask

   task automatic test_ignore_and_select();
      // hand-worked 200/13: R after each step -12,-10,-7,-1,12,11,9,5
      logic [4:0] exp_sel [0:7];
      int lat;
      exp_sel[0] = 5'b0110_1; exp_sel[1] = 5'b1001_0; exp_sel[2] = 5'b1001_0;
      exp_sel[3] = 5'b1001_0; exp_sel[4] = 5'b1001_0; exp_sel[5] = 5'b0110_1;
      exp_sel[6] = 5'b0110_1; exp_sel[7] = 5'b0110_1;
      start8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd13;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 1;
      while (!done8 && lat < 100) begin
         if (lat <= 8) begin
            total_cnt++;
            if ({alu_m8, alu_s8, alu_cin8} !== {1'b0, exp_sel[lat-1]})
               $display("FAIL sel_step%0d: got m=%b s=%b cin=%b want m=0 s=%b cin=%b",
                        lat, alu_m8, alu_s8, alu_cin8, exp_sel[lat-1][4:1], exp_sel[lat-1][0]);
            else pass_cnt++;
         end else if (lat == 9) begin
            total_cnt++;
            if ({alu_s8, alu_cin8} !== 5'b0000_0)
               $display("FAIL sel_fix: got s=%b cin=%b want s=0000 cin=0", alu_s8, alu_cin8);
            else pass_cnt++;
         end
         if (lat == 3 || lat == 9) begin
            start8 = 1'b1; dividend8 = 8'd50; divisor8 = 8'd5;
         end else begin
            start8 = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start8 = 1'b0;
      total_cnt++;
      if (lat !== 10) $display("FAIL ignore_latency: got %0d want 10", lat); else pass_cnt++;
      total_cnt++;
      if ({div_zero8, quotient8, remainder8} !== {1'b0, 8'd15, 8'd5})
         $display("FAIL ignore_results: got dz=%b q=%0d r=%0d want dz=0 q=15 r=5",
                  div_zero8, quotient8, remainder8);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op();
      int lat, busy_n, done_seen;
      start8 = 1'b1; dividend8 = 8'd100; divisor8 = 8'd7;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({busy8, done8, div_zero8, quotient8, remainder8, alu_s8, alu_m8, alu_cin8} !== '0)
         $display("FAIL midreset_outputs: got %h want 0",
                  {busy8, done8, div_zero8, quotient8, remainder8, alu_s8, alu_m8, alu_cin8});
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      done_seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done8 || busy8) done_seen++;
      end
      total_cnt++;
      if (done_seen !== 0)
         $display("FAIL midreset_no_activity: got %0d busy/done cycles want 0", done_seen);
      else pass_cnt++;
      op8(8'd100, 8'd7, lat, busy_n);
      total_cnt++;
      if ({lat[7:0], quotient8, remainder8} !== {8'd10, 8'd14, 8'd2})
         $display("FAIL midreset_recover: got lat=%0d q=%0d r=%0d want lat=10 q=14 r=2",
                  lat, quotient8, remainder8);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_wide();
      int lat;
      logic [63:0] ra, rb;
      logic [35:0] a, b;
      op36(36'hF_FFFF_FFFF, 36'h3, lat);
      total_cnt++;
      if (lat !== 38) $display("FAIL wide_latency: got %0d want 38", lat); else pass_cnt++;
      total_cnt++;
      if ({quotient36, remainder36} !== {36'h5_5555_5555, 36'h0})
         $display("FAIL wide_all_ones_by_3: got q=%h r=%h want q=555555555 r=0",
                  quotient36, remainder36);
      else pass_cnt++;
      @(posedge clk); #1;
      for (int i = 0; i < 1000; i++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         a = ra[35:0];
         b = rb[35:0] >> $urandom_range(0, 35);
         if (b == '0) b = 36'd1;
         op36(a, b, lat);
         total_cnt++;
         if ({quotient36, remainder36} !== {a / b, a % b})
            $display("FAIL wide_random%0d: %h/%h got q=%h r=%h want q=%h r=%h",
                     i, a, b, quotient36, remainder36, a / b, a % b);
         else pass_cnt++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_ignore_and_select();
      test_reset_mid_op();
      test_wide();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
